// File: rtl/sys_spi_pkg.sv
// sys_spi_pkg: opcodes, FSM encoding and CRC-8 helper
// shared by the sys_spi_cmd SPI command engine.
package sys_spi_pkg;

  localparam logic [7:0] CMD_CONF   = 8'd1;
  localparam logic [7:0] CMD_CFG    = 8'd2;
  localparam logic [7:0] CMD_OVL    = 8'd3;
  localparam logic [7:0] CMD_CUR    = 8'd4;
  localparam logic [7:0] CMD_CHR    = 8'd5;
  localparam logic [7:0] CMD_LOAD   = 8'd6;
  localparam logic [7:0] CMD_ROM    = 8'd7;
  localparam logic [7:0] CMD_STATUS = 8'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARGS,
    ST_STREAM,
    ST_READ,
    ST_DONE
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h07;

  function automatic logic [7:0] crc8_byte(
    input logic [7:0] crc,
    input logic [7:0] d
  );
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

endpackage

// File: rtl/sys_byte_fifo.sv
// sys_byte_fifo: synchronous byte FIFO with level output.
// A push while full is accepted only when a pop frees a slot.
module sys_byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign level   = wptr - rptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/sys_spi_cmd.sv
// sys_spi_cmd: SPI-slave command engine (MCU -> core).
// Optional SYS_SPI_CRC_EN adds CRC-8 over FIFO bytes.
module sys_spi_cmd
  import sys_spi_pkg::*;
#(
  parameter int CFG_REGS   = 4,
  parameter int LEN_BYTES  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int CONF_AW    = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    sspi_cs,
  input  logic                    sspi_clk,
  input  logic                    sspi_mosi,
  output logic                    sspi_miso,
  output logic [CONF_AW-1:0]      conf_addr,
  input  logic [7:0]              conf_data,
  output logic [32*CFG_REGS-1:0]  core_config,
  output logic                    overlay,
  output logic                    cur_we,
  output logic [15:0]             cur_xy,
  output logic                    chr_we,
  output logic [7:0]              chr,
  output logic                    rom_loading,
  output logic [7:0]              rom_do,
  output logic                    rom_do_valid,
  input  logic                    rom_do_ready,
  output logic                    rom_ovf
);

  localparam int LW  = 8 * LEN_BYTES;
  localparam int FAW = $clog2(FIFO_DEPTH);

  logic [1:0]    cs_q, mosi_q;
  logic [2:0]    sclk_q;
  logic          cs_s, rise, fall;
  state_t        st;
  logic [7:0]    cmd, sh, idx, tx_sh;
  logic [2:0]    bcnt, argc;
  logic [1:0]    stc;
  logic          byte_done;
  logic [23:0]   wdata;
  logic [LW-1:0] len_q, nlen;
  logic          push, full, empty;
  logic [FAW:0]  fifo_level;
  logic [7:0]    crc_byte;

  assign cs_s = cs_q[1];
  assign rise = sclk_q[1] & ~sclk_q[2];
  assign fall = ~sclk_q[1] & sclk_q[2];
  assign push = byte_done && !cs_s &&
                st == ST_STREAM && cmd == CMD_ROM;
  assign nlen = len_q | (LW'(sh) << (8 * argc));
  assign rom_do_valid = !empty;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cs_q   <= 2'b11;
      sclk_q <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[0], sspi_cs};
      sclk_q <= {sclk_q[1:0], sspi_clk};
      mosi_q <= {mosi_q[0], sspi_mosi};
    end
  end

  sys_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (sh),
    .pop    (rom_do_ready),
    .dout   (rom_do),
    .empty  (empty),
    .full   (full),
    .level  (fifo_level)
  );

`ifdef SYS_SPI_CRC_EN
  logic [7:0] crc_q;
  logic       crc_clr;
  assign crc_clr = byte_done && !cs_s &&
    ((st == ST_IDLE && sh == CMD_ROM) ||
     (st == ST_ARGS && cmd == CMD_LOAD));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      crc_q <= '0;
    else if (crc_clr)
      crc_q <= '0;
    else if (push && (!full || rom_do_ready))
      crc_q <= crc8_byte(crc_q, sh);
  end
  assign crc_byte = crc_q;
`else
  assign crc_byte = 8'h00;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st          <= ST_IDLE;
      cmd         <= '0;
      sh          <= '0;
      idx         <= '0;
      tx_sh       <= '0;
      bcnt        <= '0;
      argc        <= '0;
      stc         <= '0;
      byte_done   <= 1'b0;
      wdata       <= '0;
      len_q       <= '0;
      sspi_miso   <= 1'b0;
      conf_addr   <= '0;
      core_config <= '0;
      overlay     <= 1'b0;
      cur_we      <= 1'b0;
      cur_xy      <= '0;
      chr_we      <= 1'b0;
      chr         <= '0;
      rom_loading <= 1'b0;
      rom_ovf     <= 1'b0;
    end else begin
      cur_we    <= 1'b0;
      chr_we    <= 1'b0;
      byte_done <= 1'b0;
      if (push && full && !rom_do_ready)
        rom_ovf <= 1'b1;
      if (cs_s) begin
        st        <= ST_IDLE;
        bcnt      <= '0;
        sh        <= '0;
        len_q     <= '0;
        tx_sh     <= '0;
        sspi_miso <= 1'b0;
        conf_addr <= '0;
      end else begin
        if (rise) begin
          sh        <= {sh[6:0], mosi_q[1]};
          bcnt      <= bcnt + 1'b1;
          byte_done <= (bcnt == 3'd7);
        end
        if (fall) begin
          sspi_miso <= tx_sh[7];
          tx_sh     <= {tx_sh[6:0], 1'b0};
        end
        // a completed byte reloads tx_sh ahead of its first fall
        if (byte_done) begin
          unique case (st)
            ST_IDLE: begin
              cmd   <= sh;
              argc  <= '0;
              len_q <= '0;
              case (sh)
                CMD_CONF: begin
                  st        <= ST_READ;
                  tx_sh     <= conf_data;
                  conf_addr <= conf_addr + 1'b1;
                end
                CMD_STATUS: begin
                  st    <= ST_READ;
                  tx_sh <= 8'(fifo_level);
                  stc   <= 2'd1;
                end
                CMD_CFG, CMD_OVL, CMD_CUR,
                CMD_LOAD, CMD_ROM: st <= ST_ARGS;
                CMD_CHR:           st <= ST_STREAM;
                default:           st <= ST_DONE;
              endcase
            end
            ST_ARGS: begin
              argc  <= argc + 1'b1;
              wdata <= {sh, wdata[23:8]};
              case (cmd)
                CMD_CFG: begin
                  if (argc == 3'd0)
                    idx <= sh;
                  if (argc == 3'd4) begin
                    for (int i = 0; i < CFG_REGS; i++)
                      if (idx == 8'(i))
                        core_config[32*i +: 32] <= {sh, wdata};
                    st <= ST_DONE;
                  end
                end
                CMD_OVL: begin
                  overlay <= sh[0];
                  st      <= ST_DONE;
                end
                CMD_CUR: begin
                  if (argc == 3'd1) begin
                    cur_xy <= {sh, wdata[23:16]};
                    cur_we <= 1'b1;
                    st     <= ST_DONE;
                  end
                end
                CMD_LOAD: begin
                  rom_loading <= sh[0];
                  rom_ovf     <= 1'b0;
                  st          <= ST_DONE;
                end
                CMD_ROM: begin
                  len_q <= nlen;
                  if (argc == 3'(LEN_BYTES - 1))
                    st <= (nlen == '0) ? ST_DONE : ST_STREAM;
                end
                default: st <= ST_DONE;
              endcase
            end
            ST_STREAM: begin
              if (cmd == CMD_CHR) begin
                if (sh == 8'h00) begin
                  st <= ST_DONE;
                end else begin
                  chr    <= sh;
                  chr_we <= 1'b1;
                end
              end else begin
                len_q <= len_q - 1'b1;
                if (len_q == LW'(1))
                  st <= ST_DONE;
              end
            end
            ST_READ: begin
              if (cmd == CMD_CONF) begin
                tx_sh     <= conf_data;
                conf_addr <= conf_addr + 1'b1;
              end else begin
                case (stc)
                  2'd1:    tx_sh <= {6'b0, rom_ovf, rom_loading};
                  2'd2:    tx_sh <= crc_byte;
                  default: tx_sh <= 8'h00;
                endcase
                if (stc != 2'd3)
                  stc <= stc + 2'd1;
              end
            end
            ST_DONE: ;
            default: st <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule
